// File: rtl/hwmod_pkg.sv
// hwmod_pkg: definitions shared by the hw-mod violation handling blocks.
//   - vrc_state_t      : viol_reset_ctrl FSM encoding (IDLE/HOLD/WAIT)
//   - RESET_HANDLER    : PC value that proves the CPU has restarted
//   - VIOL_*           : bit positions of the violation sources in viol_in
package hwmod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        WAIT = 2'b10
    } vrc_state_t;

    localparam logic [15:0] RESET_HANDLER = 16'hfffe;

    localparam int VIOL_ATOM  = 0;
    localparam int VIOL_KEY   = 1;
    localparam int VIOL_DMA   = 2;
    localparam int VIOL_STACK = 3;

endpackage

// File: rtl/viol_cause_log.sv
// viol_cause_log: sticky record of which sources caused a reset, plus a
// saturating count of triggered resets, for post-mortem attestation.
// Ports:
//   clk, rst     : clock, asynchronous active-high clear
//   log_en       : one-cycle strobe on each new (non-retry) violation
//   cause_in     : violation vector sampled with log_en
//   reset_cause  : sticky OR of all logged cause vectors
//   viol_count   : number of logged violations, saturating at all-ones
module viol_cause_log #(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               log_en,
    input  logic [NUM_SRC-1:0] cause_in,
    output logic [NUM_SRC-1:0] reset_cause,
    output logic [CNT_W-1:0]   viol_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reset_cause <= '0;
            viol_count  <= '0;
        end else if (log_en) begin
            reset_cause <= reset_cause | cause_in;
            viol_count  <= sat_inc(viol_count);
        end
    end

endmodule

// File: rtl/viol_reset_ctrl.sv
// viol_reset_ctrl: turns hw-mod violation flags into a fixed-width system
// reset pulse (PUC request) and masks the monitors' sticky outputs until the
// CPU is seen back at the reset handler. If the handler is not reached within
// WAIT_TIMEOUT cycles the reset pulse is re-issued.
// Optional build macro: VRESET_CAUSE_LOG_EN enables the cause/count log
// (viol_cause_log); without it reset_cause and viol_count are tied to 0.
// Ports:
//   clk          : system clock
//   rst          : asynchronous active-high reset
//   pc           : current CPU program counter
//   viol_in      : level violation requests (atomicity, key, DMA, stack)
//   sys_reset    : registered reset request to the CPU
//   busy         : high while in HOLD or WAIT
//   reset_cause  : sticky cause vector (log build only)
//   viol_count   : saturating reset count (log build only)
module viol_reset_ctrl #(
    parameter int          NUM_SRC       = 4,
    parameter logic [15:0] RESET_HANDLER = hwmod_pkg::RESET_HANDLER,
    parameter int          HOLD_CYCLES   = 8,
    parameter int          WAIT_TIMEOUT  = 256,
    parameter int          CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        pc,
    input  logic [NUM_SRC-1:0] viol_in,
    output logic               sys_reset,
    output logic               busy,
    output logic [NUM_SRC-1:0] reset_cause,
    output logic [CNT_W-1:0]   viol_count
);

    import hwmod_pkg::*;

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int TMR_W  = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(WAIT_TIMEOUT - 1);

    vrc_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TMR_W-1:0]  timer;

    // Reset lands in WAIT: the monitors power up asserted, so violations stay
    // masked until the CPU proves it reached the reset handler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT;
            hold_cnt  <= '0;
            timer     <= '0;
            sys_reset <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|viol_in) begin
                        state     <= HOLD;
                        hold_cnt  <= HOLD_LOAD;
                        sys_reset <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state     <= WAIT;
                        timer     <= '0;
                        sys_reset <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                WAIT: begin
                    // Handler match has priority over a coincident timeout.
                    if (pc == RESET_HANDLER) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (timer == TMR_LAST) begin
                        // Retry pulse: not a new violation, so nothing logged.
                        state     <= HOLD;
                        hold_cnt  <= HOLD_LOAD;
                        sys_reset <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    state     <= WAIT;
                    timer     <= '0;
                    sys_reset <= 1'b0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

`ifdef VRESET_CAUSE_LOG_EN
    logic log_en;

    // Only genuine IDLE->HOLD transitions are logged.
    assign log_en = (state == IDLE) && (|viol_in);

    viol_cause_log #(
        .NUM_SRC (NUM_SRC),
        .CNT_W   (CNT_W)
    ) u_log (
        .clk         (clk),
        .rst         (rst),
        .log_en      (log_en),
        .cause_in    (viol_in),
        .reset_cause (reset_cause),
        .viol_count  (viol_count)
    );
`else
    assign reset_cause = '0;
    assign viol_count  = '0;
`endif

endmodule

// File: tb/tb_viol_reset_ctrl.sv
module tb_viol_reset_ctrl;
    import hwmod_pkg::*;

`ifdef VRESET_CAUSE_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic [3:0]  viol_in;
    logic        sys_reset;
    logic        busy;
    logic [3:0]  reset_cause;
    logic [1:0]  viol_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    viol_reset_ctrl #(
        .NUM_SRC       (4),
        .RESET_HANDLER (16'hfffe),
        .HOLD_CYCLES   (8),
        .WAIT_TIMEOUT  (256),
        .CNT_W         (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .viol_in     (viol_in),
        .sys_reset   (sys_reset),
        .busy        (busy),
        .reset_cause (reset_cause),
        .viol_count  (viol_count)
    );

    // Present the handler PC for one edge with no violation, then move away.
    task automatic go_idle();
        viol_in = 4'b0000;
        pc      = 16'hfffe;
        @(negedge clk);
        pc      = 16'h4000;
    endtask

    task automatic test_power_up();
        rst = 1'b1; pc = 16'h4000; viol_in = 4'b0001;
        repeat (2) @(negedge clk);
        checks++;
        if (sys_reset !== 1'b0 || busy !== 1'b1 || reset_cause !== 4'b0 || viol_count !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got sr=%b busy=%b cause=%b cnt=%0d exp sr=0 busy=1 cause=0000 cnt=0",
                     sys_reset, busy, reset_cause, viol_count);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (sys_reset !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL powerup_mask[%0d] got sr=%b busy=%b exp sr=0 busy=1", i, sys_reset, busy);
            end
        end
        pc = 16'hfffe;
        @(negedge clk);
        checks++;
        if (sys_reset !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL powerup_handler got sr=%b busy=%b exp sr=0 busy=0", sys_reset, busy);
        end
        viol_in = 4'b0000; pc = 16'h4000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (sys_reset !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL powerup_idle[%0d] got sr=%b busy=%b exp sr=0 busy=0", i, sys_reset, busy);
            end
        end
    endtask

    task automatic test_atomicity();
        viol_in = 4'b0001 << VIOL_ATOM;
        @(negedge clk);
        viol_in = 4'b0000;
        checks++;
        if (sys_reset !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL atom_latency got sr=%b busy=%b exp sr=1 busy=1", sys_reset, busy);
        end
        checks++;
        if (reset_cause !== (LOG ? 4'b0001 : 4'b0000) || viol_count !== (LOG ? 2'd1 : 2'd0)) begin
            failures++;
            $display("FAIL atom_log got cause=%b cnt=%0d exp cause=%b cnt=%0d",
                     reset_cause, viol_count, LOG ? 4'b0001 : 4'b0000, LOG ? 1 : 0);
        end
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (sys_reset !== 1'b1 || busy !== 1'b1) begin
                failures++;
                $display("FAIL atom_pulse[%0d] got sr=%b busy=%b exp sr=1 busy=1", i, sys_reset, busy);
            end
        end
        @(negedge clk);
        checks++;
        if (sys_reset !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL atom_pulse_end got sr=%b busy=%b exp sr=0 busy=1", sys_reset, busy);
        end
    endtask

    task automatic test_timeout_retry();
        int n = 0;
        while (sys_reset !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 256) begin
            failures++;
            $display("FAIL retry_wait_cycles got %0d exp 256", n);
        end
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (sys_reset !== 1'b1) begin
                failures++;
                $display("FAIL retry_pulse[%0d] got sr=%b exp 1", i, sys_reset);
            end
        end
        @(negedge clk);
        checks++;
        if (sys_reset !== 1'b0) begin
            failures++;
            $display("FAIL retry_pulse_end got sr=%b exp 0", sys_reset);
        end
        checks++;
        if (reset_cause !== (LOG ? 4'b0001 : 4'b0000) || viol_count !== (LOG ? 2'd1 : 2'd0)) begin
            failures++;
            $display("FAIL retry_log got cause=%b cnt=%0d exp cause=%b cnt=%0d",
                     reset_cause, viol_count, LOG ? 4'b0001 : 4'b0000, LOG ? 1 : 0);
        end
        go_idle();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL retry_to_idle got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_async_rst_mid_hold();
        viol_in = 4'b0001 << VIOL_DMA;
        @(negedge clk);
        viol_in = 4'b0000;
        checks++;
        if (sys_reset !== 1'b1 || viol_count !== (LOG ? 2'd2 : 2'd0)) begin
            failures++;
            $display("FAIL arst_pre got sr=%b cnt=%0d exp sr=1 cnt=%0d", sys_reset, viol_count, LOG ? 2 : 0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (sys_reset !== 1'b0 || busy !== 1'b1 || reset_cause !== 4'b0 || viol_count !== 2'd0) begin
            failures++;
            $display("FAIL arst_async got sr=%b busy=%b cause=%b cnt=%0d exp sr=0 busy=1 cause=0000 cnt=0",
                     sys_reset, busy, reset_cause, viol_count);
        end
        @(negedge clk);
        rst = 1'b0;
        viol_in = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (sys_reset !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL arst_wait_mask[%0d] got sr=%b busy=%b exp sr=0 busy=1", i, sys_reset, busy);
            end
        end
        go_idle();
        checks++;
        if (busy !== 1'b0 || sys_reset !== 1'b0) begin
            failures++;
            $display("FAIL arst_to_idle got sr=%b busy=%b exp sr=0 busy=0", sys_reset, busy);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        viol_in = 4'b0110;
        @(negedge clk);
        viol_in = 4'b0000;
        checks++;
        if (reset_cause !== (LOG ? 4'b0110 : 4'b0000) || viol_count !== (LOG ? 2'd1 : 2'd0)) begin
            failures++;
            $display("FAIL simul_log1 got cause=%b cnt=%0d exp cause=%b cnt=%0d",
                     reset_cause, viol_count, LOG ? 4'b0110 : 4'b0000, LOG ? 1 : 0);
        end
        n = (sys_reset === 1'b1) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sys_reset !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL simul_single_pulse got width=%0d exp 8", n);
        end
        go_idle();
        viol_in = 4'b0001 << VIOL_STACK;
        @(negedge clk);
        viol_in = 4'b0000;
        checks++;
        if (reset_cause !== (LOG ? 4'b1110 : 4'b0000) || viol_count !== (LOG ? 2'd2 : 2'd0)) begin
            failures++;
            $display("FAIL simul_log2 got cause=%b cnt=%0d exp cause=%b cnt=%0d",
                     reset_cause, viol_count, LOG ? 4'b1110 : 4'b0000, LOG ? 2 : 0);
        end
        repeat (8) @(negedge clk);
        go_idle();
    endtask

    task automatic test_saturation_back_to_back();
        logic [1:0] exp_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        go_idle();
        for (int k = 1; k <= 5; k++) begin
            viol_in = 4'b1000;
            @(negedge clk);
            viol_in = 4'b0000;
            exp_cnt = LOG ? ((k > 3) ? 2'd3 : 2'(k)) : 2'd0;
            checks++;
            if (sys_reset !== 1'b1) begin
                failures++;
                $display("FAIL b2b_accept[%0d] got sr=%b exp 1", k, sys_reset);
            end
            checks++;
            if (viol_count !== exp_cnt || reset_cause !== (LOG ? 4'b1000 : 4'b0000)) begin
                failures++;
                $display("FAIL sat_count[%0d] got cnt=%0d cause=%b exp cnt=%0d cause=%b",
                         k, viol_count, reset_cause, exp_cnt, LOG ? 4'b1000 : 4'b0000);
            end
            repeat (8) @(negedge clk);
            checks++;
            if (sys_reset !== 1'b0) begin
                failures++;
                $display("FAIL sat_pulse_end[%0d] got sr=%b exp 0", k, sys_reset);
            end
            go_idle();
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL sat_to_idle[%0d] got busy=%b exp 0", k, busy);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; pc = 16'h4000; viol_in = 4'b0000;
        test_power_up();
        test_atomicity();
        test_timeout_retry();
        test_async_rst_mid_hold();
        test_simultaneous();
        test_saturation_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
